shift_arbiter: RTL and testbench

Arbitrates the single 32-bit barrel shifter (`Shifter_32`) between two requesters: the ALU shift path (port 0) and the load/store byte-lane aligner (port 1). Each requester uses a valid/ready request channel. Each accepted shift produces one registered result on a shared response channel, tagged with the requester ID. The block sits in the execute stage, between the decode/issue logic and the writeback mux.

---
 rtl/shift_pkg.sv | 18 +
 rtl/Shifter_32.sv | 21 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/shift_arbiter.sv | 86 ++++++++
 tb/tb_shift_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the execute-stage shifter arbiter.
// Requester IDs and the packed shift-request bundle.
package shift_pkg;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    localparam logic SHIFT_ID_ALU = 1'b0;
    localparam logic SHIFT_ID_LSU = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [SHW-1:0]  shamt;
        logic            right;
        logic            sra;
    } shift_req_t;

endpackage

// File: rtl/Shifter_32.sv
// Fixed-width 32-bit barrel shifter: left, logical right, arithmetic right.
// Purely combinational; shamt is naturally modulo 32 by its width.
module Shifter_32 (
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic        right,
    input  logic        arith,
    output logic [31:0] y
);

    always_comb begin
        y = a;
        if (!right)
            y = a << shamt;
        else if (arith)
            y = $unsigned($signed(a) >>> shamt);
        else
            y = a >> shamt;
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-input grant; SHIFT_ARB_RR_EN selects round-robin on conflict,
// otherwise port 0 has fixed priority and last_id is ignored.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_id,
    output logic [1:0] gnt
);

`ifdef SHIFT_ARB_RR_EN
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11)
            gnt = last_id ? 2'b01 : 2'b10;
        else if (req[0])
            gnt = 2'b01;
        else if (req[1])
            gnt = 2'b10;
    end
`else
    logic unused_last_id;
    assign unused_last_id = last_id;

    always_comb begin
        gnt = 2'b00;
        if (req[0])
            gnt = 2'b01;
        else if (req[1])
            gnt = 2'b10;
    end
`endif

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates Shifter_32 between ALU (port 0) and LSU aligner (port 1).
// Optional macro SHIFT_ARB_RR_EN enables round-robin conflict grant.
module shift_arbiter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [XLEN-1:0] r0_data,
    input  logic [SHW-1:0]  r0_shamt,
    input  logic            r0_right,
    input  logic            r0_sra,
    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [XLEN-1:0] r1_data,
    input  logic [SHW-1:0]  r1_shamt,
    input  logic            r1_right,
    input  logic            r1_sra,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_id
);

    import shift_pkg::*;

    logic       last_id;
    logic       slot_free;
    logic [1:0] gnt;
    logic       acc0;
    logic       acc1;
    logic       acc;
    shift_req_t req0;
    shift_req_t req1;
    shift_req_t sel;
    logic [31:0] sh_out;

    assign req0 = '{data: r0_data, shamt: r0_shamt,
                    right: r0_right, sra: r0_sra};
    assign req1 = '{data: r1_data, shamt: r1_shamt,
                    right: r1_right, sra: r1_sra};

    rr_arb2 u_arb (
        .req     ({r1_valid, r0_valid}),
        .last_id (last_id),
        .gnt     (gnt)
    );

    // Ready depends on rsp_ready so the slot can refill on the drain cycle.
    assign slot_free = !rsp_valid || rsp_ready;
    assign r0_ready  = !rst && slot_free && gnt[0];
    assign r1_ready  = !rst && slot_free && gnt[1];

    assign acc0 = r0_valid && r0_ready;
    assign acc1 = r1_valid && r1_ready;
    assign acc  = acc0 || acc1;

    assign sel = acc1 ? req1 : req0;

    Shifter_32 u_shift (
        .a     (sel.data),
        .shamt (sel.shamt),
        .right (sel.right),
        .arith (sel.sra),
        .y     (sh_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= SHIFT_ID_ALU;
            last_id   <= SHIFT_ID_LSU;
        end else if (acc) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sh_out;
            rsp_id    <= acc1 ? SHIFT_ID_LSU : SHIFT_ID_ALU;
            last_id   <= acc1 ? SHIFT_ID_LSU : SHIFT_ID_ALU;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized self-checking bench for shift_arbiter.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_data = '0, r1_data = '0;
    logic [4:0]  r0_shamt = '0, r1_shamt = '0;
    logic        r0_right = 1'b0, r1_right = 1'b0;
    logic        r0_sra = 1'b0, r1_sra = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_id;

    int tests = 0;
    int failed = 0;

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data),
        .r0_shamt(r0_shamt), .r0_right(r0_right), .r0_sra(r0_sra),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data),
        .r1_shamt(r1_shamt), .r1_right(r1_right), .r1_sra(r1_sra),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d,
        input logic [4:0] s, input logic r, input logic a);
        logic [31:0] v;
        v = d;
        for (int k = 0; k < 32; k++) begin
            if (k < int'(s)) begin
                if (!r)     v = {v[30:0], 1'b0};
                else if (a) v = {d[31], v[31:1]};
                else        v = {1'b0, v[31:1]};
            end
        end
        return v;
    endfunction

    task automatic do_req(input bit port, input logic [31:0] d,
        input logic [4:0] s, input logic r, input logic a,
        input logic [31:0] exp, input string tag);
        rsp_ready = 1'b1;
        if (port) begin
            r1_valid = 1'b1; r1_data = d; r1_shamt = s;
            r1_right = r; r1_sra = a;
        end else begin
            r0_valid = 1'b1; r0_data = d; r0_shamt = s;
            r0_right = r; r0_sra = a;
        end
        #1;
        check({tag, "_rdy"}, 32'(port ? r1_ready : r0_ready), 32'd1);
        step();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, rsp_data, exp);
        check({tag, "_id"}, 32'(rsp_id), 32'(port));
        step();
        check({tag, "_drain"}, 32'(rsp_valid), 32'd0);
    endtask

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    initial begin
        logic exp_id[4];
        logic [31:0] hold_data;
        logic hold_id;
        logic p_v[2];
        logic [31:0] p_d[2];
        logic [4:0] p_s[2];
        logic p_r[2];
        logic p_a[2];
        logic a0, a1, hs, hid;
        logic [31:0] hdata, e;

        r0_valid = 1'b1;
        r1_valid = 1'b1;
        #1;
        check("rst_rdy0", 32'(r0_ready), 32'd0);
        check("rst_rdy1", 32'(r1_ready), 32'd0);
        step();
        step();
        check("rst_vld", 32'(rsp_valid), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst = 1'b0;
        step();

        do_req(1'b0, 32'hA5A5A5A5, 5'd4, 1'b1, 1'b1, 32'hFA5A5A5A, "p0_sra");
        do_req(1'b0, 32'h80000000, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF, "p0_sra31");
        do_req(1'b0, 32'h00000001, 5'd31, 1'b0, 1'b1, 32'h80000000, "p0_sll31");
        do_req(1'b1, 32'hA5A5A5A5, 5'd4, 1'b1, 1'b0, 32'h0A5A5A5A, "p1_srl");
        do_req(1'b1, 32'hA5A5A5A5, 5'd4, 1'b0, 1'b0, 32'h5A5A5A50, "p1_sll");
        do_req(1'b1, 32'hA5A5A5A5, 5'd0, 1'b1, 1'b1, 32'hA5A5A5A5, "p1_sh0");

        // last_id is 1 here, so round-robin starts with port 0
`ifdef SHIFT_ARB_RR_EN
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        r0_data = 32'h1;  r0_shamt = 5'd1; r0_right = 1'b0; r0_sra = 1'b0;
        r1_data = 32'h80; r1_shamt = 5'd4; r1_right = 1'b1; r1_sra = 1'b0;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("conf_id%0d", i), 32'(rsp_id), 32'(exp_id[i]));
            check($sformatf("conf_data%0d", i), rsp_data,
                  exp_id[i] ? 32'h8 : 32'h2);
        end

        hold_id = exp_id[3];
        hold_data = hold_id ? 32'h8 : 32'h2;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_rdy0_%0d", i), 32'(r0_ready), 32'd0);
            check($sformatf("stall_rdy1_%0d", i), 32'(r1_ready), 32'd0);
            step();
            check($sformatf("stall_vld%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("stall_data%0d", i), rsp_data, hold_data);
            check($sformatf("stall_id%0d", i), 32'(rsp_id), 32'(hold_id));
        end
        rsp_ready = 1'b1;
        #1;
        check("unstall_rdy0", 32'(r0_ready), 32'd1);
        check("unstall_rdy1", 32'(r1_ready), 32'd0);
        step();
        check("unstall_id", 32'(rsp_id), 32'd0);
        check("unstall_data", rsp_data, 32'h2);

        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mrst_rdy0", 32'(r0_ready), 32'd0);
        check("mrst_rdy1", 32'(r1_ready), 32'd0);
        step();
        check("mrst_vld", 32'(rsp_valid), 32'd0);
        check("mrst_rdy0b", 32'(r0_ready), 32'd0);
        check("mrst_rdy1b", 32'(r1_ready), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("post_rst_rdy0", 32'(r0_ready), 32'd1);
        check("post_rst_rdy1", 32'(r1_ready), 32'd0);
        step();
        check("post_rst_id", 32'(rsp_id), 32'd0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        step();
        step();

        p_v = '{1'b0, 1'b0};
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_v[p] && i < 340 && $urandom_range(1, 0) == 1) begin
                    p_v[p] = 1'b1;
                    p_d[p] = $urandom;
                    p_s[p] = 5'($urandom_range(31, 0));
                    p_r[p] = 1'($urandom_range(1, 0));
                    p_a[p] = 1'($urandom_range(1, 0));
                end
            end
            r0_valid = p_v[0]; r0_data = p_d[0]; r0_shamt = p_s[0];
            r0_right = p_r[0]; r0_sra = p_a[0];
            r1_valid = p_v[1]; r1_data = p_d[1]; r1_shamt = p_s[1];
            r1_right = p_r[1]; r1_sra = p_a[1];
            rsp_ready = (i >= 340) ? 1'b1 : 1'($urandom_range(1, 0));
            #1;
            if (r0_ready && r1_ready)
                check("rnd_both_rdy", 32'd1, 32'd0);
            if ((r0_ready || r1_ready) && rsp_valid && !rsp_ready)
                check("rnd_rdy_full", 32'd1, 32'd0);
            a0 = r0_valid && r0_ready;
            a1 = r1_valid && r1_ready;
            hs = rsp_valid && rsp_ready;
            hid = rsp_id;
            hdata = rsp_data;
            step();
            if (hs) begin
                if (hid) begin
                    if (q1.size() == 0) check("rnd_dup1", 32'd1, 32'd0);
                    else check("rnd_data1", hdata, q1.pop_front());
                end else begin
                    if (q0.size() == 0) check("rnd_dup0", 32'd1, 32'd0);
                    else check("rnd_data0", hdata, q0.pop_front());
                end
            end
            if (a0) begin
                e = ref_shift(p_d[0], p_s[0], p_r[0], p_a[0]);
                q0.push_back(e);
                p_v[0] = 1'b0;
            end
            if (a1) begin
                e = ref_shift(p_d[1], p_s[1], p_r[1], p_a[1]);
                q1.push_back(e);
                p_v[1] = 1'b0;
            end
        end
        check("rnd_q0_empty", 32'(q0.size()), 32'd0);
        check("rnd_q1_empty", 32'(q1.size()), 32'd0);
        check("rnd_pend0", 32'(p_v[0]), 32'd0);
        check("rnd_pend1", 32'(p_v[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
